// File: rtl/norm_pipe.sv
// Two-stage post-add normaliser: S1 registers the operands plus a leading-zero
// count, S2 registers the shifted fraction, adjusted exponent and flags.
module norm_pipe #(
  parameter int MW     = 24,
  parameter int EW     = 8,
  parameter int DENORM = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [MW-1:0] in_mant_i,
  input  logic          in_of_i,
  input  logic [EW-1:0] in_exp_i,
  input  logic          in_sign_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [MW-2:0] out_mant_o,
  output logic [EW-1:0] out_exp_o,
  output logic          out_sign_o,
  output logic          out_zero_o,
  output logic          out_uflow_o,
  output logic          out_oflow_o,
  output logic          out_sticky_o
);
  localparam int LZW = $clog2(MW + 1);
  localparam int XW  = EW + 2;
  localparam logic signed [XW-1:0] ONE_X   = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);

  logic           s1_valid_q, s1_valid_d;
  logic [MW-1:0]  s1_mant_q;
  logic           s1_of_q;
  logic [EW-1:0]  s1_exp_q;
  logic           s1_sign_q;
  logic [LZW-1:0] s1_lz_q;
  logic [LZW-1:0] lz;

  logic           s2_valid_d;
  logic [MW-2:0]  mant_d;
  logic [EW-1:0]  exp_d;
  logic           zero_d, uflow_d, oflow_d, sticky_d;

  logic           s1_load, s2_load;

  // Valid/ready: a word moves on any edge where valid & ready are both high.
  // A stage loads when empty or when the stage after it drains; no skid buffer.
  assign s2_load    = !out_valid_o | out_ready_i;
  assign s1_load    = !s1_valid_q | s2_load;
  assign in_ready_o = s1_load;
  assign s1_valid_d = s1_load ? in_valid_i : s1_valid_q;
  assign s2_valid_d = s2_load ? s1_valid_q : out_valid_o;

  always_comb begin
    lz = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (in_mant_i[i]) lz = LZW'(MW - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_of_q    <= 1'b0;
      s1_exp_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_lz_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load && in_valid_i) begin
        s1_mant_q <= in_mant_i;
        s1_of_q   <= in_of_i;
        s1_exp_q  <= in_exp_i;
        s1_sign_q <= in_sign_i;
        s1_lz_q   <= lz;
      end
    end
  end

  logic signed [XW-1:0] exp_x, lz_x, exp_inc, exp_norm;
  logic [LZW-1:0]       sh;
  logic [MW-1:0]        mant_sh;

  assign exp_x    = signed'(XW'(s1_exp_q));
  assign lz_x     = signed'(XW'(s1_lz_q));
  assign exp_inc  = exp_x + ONE_X;
  assign exp_norm = exp_x - lz_x;

  always_comb begin
    mant_d   = '0;
    exp_d    = '0;
    zero_d   = 1'b0;
    uflow_d  = 1'b0;
    oflow_d  = 1'b0;
    sticky_d = 1'b0;
    sh       = '0;
    mant_sh  = '0;
    if (s1_of_q) begin
      sticky_d = s1_mant_q[0];
      if (exp_inc >= EXP_MAX) begin
        oflow_d = 1'b1;
        exp_d   = '1;
      end else begin
        mant_d = s1_mant_q[MW-1:1];
        exp_d  = exp_inc[EW-1:0];
      end
    end else if (s1_mant_q == '0) begin
      zero_d = 1'b1;
    end else if (exp_norm >= ONE_X) begin
      sh      = s1_lz_q;
      mant_sh = s1_mant_q << sh;
      mant_d  = mant_sh[MW-2:0];
      exp_d   = exp_norm[EW-1:0];
    end else begin
      // Exponent would go below 1: shift only as far as exponent 1 allows.
      uflow_d = 1'b1;
      if (DENORM != 0) begin
        if (s1_exp_q != '0) sh = LZW'(s1_exp_q - 1'b1);
        mant_sh = s1_mant_q << sh;
        mant_d  = mant_sh[MW-2:0];
      end else begin
        zero_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o  <= 1'b0;
      out_mant_o   <= '0;
      out_exp_o    <= '0;
      out_sign_o   <= 1'b0;
      out_zero_o   <= 1'b0;
      out_uflow_o  <= 1'b0;
      out_oflow_o  <= 1'b0;
      out_sticky_o <= 1'b0;
    end else begin
      out_valid_o <= s2_valid_d;
      if (s2_load && s1_valid_q) begin
        out_mant_o   <= mant_d;
        out_exp_o    <= exp_d;
        out_sign_o   <= s1_sign_q;
        out_zero_o   <= zero_d;
        out_uflow_o  <= uflow_d;
        out_oflow_o  <= oflow_d;
        out_sticky_o <= sticky_d;
      end
    end
  end
endmodule
